// File: rtl/apogeo_pkg.sv
// -----------------------------------------------------------------------------
// apogeo_pkg
//   Shared definitions for the timer event scheduler:
//   - register addresses of the timer block's compare/value registers
//   - FSM state encoding of the scheduler
// -----------------------------------------------------------------------------
package apogeo_pkg;

    // Timer register map (2-bit word address on the timer write port)
    localparam logic [1:0] COMPARE_LOW      = 2'd0;
    localparam logic [1:0] COMPARE_HIGH     = 2'd1;
    localparam logic [1:0] TIMER_VALUE_LOW  = 2'd2;
    localparam logic [1:0] TIMER_VALUE_HIGH = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WR_HI_MAX,
        WR_LO,
        WR_HI,
        FIRE
    } timer_sched_state_t;

endpackage

// File: rtl/timer_event_scheduler.sv
// -----------------------------------------------------------------------------
// timer_event_scheduler
//   Multiplexes NUM_SLOTS software timer events onto one 64-bit hardware
//   compare register. After every arm/cancel/fire the slot table is scanned
//   for the earliest armed deadline, which is then programmed into the timer
//   (high word parked at all ones first so a half-written compare can never
//   match early). Expired slots raise a per-slot pending flag.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   arm_valid_i/arm_ready_o    arm request handshake (ready only in IDLE)
//   arm_slot_i, arm_deadline_i slot and absolute 64-bit deadline to arm
//   cancel_valid_i/slot_i      disarm request (accepted only in IDLE)
//   timer_value_i              current 64-bit timer count
//   timer_interrupt_i          level compare-match from the timer
//   timer_write_o/_data_o/_address_o   timer register write port
//   event_pending_o/event_ack_i        pending flags, write-1-to-clear acks
//   irq_o                      OR of all pending flags
// -----------------------------------------------------------------------------
module timer_event_scheduler
    import apogeo_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         arm_valid_i,
    output logic                         arm_ready_o,
    input  logic [$clog2(NUM_SLOTS)-1:0] arm_slot_i,
    input  logic [63:0]                  arm_deadline_i,
    input  logic                         cancel_valid_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] cancel_slot_i,
    input  logic [63:0]                  timer_value_i,
    input  logic                         timer_interrupt_i,
    output logic                         timer_write_o,
    output logic [31:0]                  timer_write_data_o,
    output logic [1:0]                   timer_write_address_o,
    output logic [NUM_SLOTS-1:0]         event_pending_o,
    input  logic [NUM_SLOTS-1:0]         event_ack_i,
    output logic                         irq_o
);

    localparam int            SW       = $clog2(NUM_SLOTS);
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_SLOTS - 1);

    timer_sched_state_t   state_reg, state_next;
    logic [NUM_SLOTS-1:0] armed_reg;
    logic [63:0]          deadline_reg [NUM_SLOTS];
    logic [63:0]          min_deadline_reg, min_deadline_next;
    logic                 found_reg, found_next;
    logic [SW-1:0]        scan_idx_reg;
    logic [NUM_SLOTS-1:0] pending_reg, pending_next;
    logic [NUM_SLOTS-1:0] expired;
    logic                 arm_accept, cancel_accept, in_fire;

    assign arm_ready_o   = (state_reg == IDLE);
    assign arm_accept    = arm_valid_i && arm_ready_o;
    assign cancel_accept = cancel_valid_i && arm_ready_o;
    assign in_fire       = (state_reg == FIRE);

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_expired
            assign expired[gi] = armed_reg[gi] && (deadline_reg[gi] <= timer_value_i);
        end
    endgenerate

    // One slot per SCAN cycle folded into the running minimum. The first armed
    // slot always wins so a deadline of all ones still counts as found.
    always_comb begin
        min_deadline_next = min_deadline_reg;
        found_next        = found_reg;
        if (armed_reg[scan_idx_reg] &&
            (!found_reg || (deadline_reg[scan_idx_reg] < min_deadline_reg))) begin
            min_deadline_next = deadline_reg[scan_idx_reg];
            found_next        = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // A new request outranks a simultaneous interrupt; the
                // expired check at the end of SCAN catches it instead.
                if (arm_accept || cancel_accept)
                    state_next = SCAN;
                else if (timer_interrupt_i && (|armed_reg))
                    state_next = FIRE;
            end
            SCAN: begin
                if (scan_idx_reg == LAST_IDX)
                    state_next = (found_next && (min_deadline_next <= timer_value_i))
                                 ? FIRE : WR_HI_MAX;
            end
            WR_HI_MAX: state_next = WR_LO;
            WR_LO:     state_next = WR_HI;
            WR_HI:     state_next = IDLE;
            FIRE:      state_next = SCAN;
            default:   state_next = IDLE;
        endcase
    end

    // Moore write port. When nothing was found the minimum is still all ones,
    // which is exactly the "never fire" compare target.
    always_comb begin
        timer_write_o         = 1'b0;
        timer_write_data_o    = 32'd0;
        timer_write_address_o = COMPARE_LOW;
        case (state_reg)
            WR_HI_MAX: begin
                timer_write_o         = 1'b1;
                timer_write_data_o    = 32'hFFFF_FFFF;
                timer_write_address_o = COMPARE_HIGH;
            end
            WR_LO: begin
                timer_write_o         = 1'b1;
                timer_write_data_o    = min_deadline_reg[31:0];
                timer_write_address_o = COMPARE_LOW;
            end
            WR_HI: begin
                timer_write_o         = 1'b1;
                timer_write_data_o    = min_deadline_reg[63:32];
                timer_write_address_o = COMPARE_HIGH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            min_deadline_reg <= '1;
            found_reg        <= 1'b0;
            scan_idx_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SCAN) begin
                min_deadline_reg <= min_deadline_next;
                found_reg        <= found_next;
                scan_idx_reg     <= (scan_idx_reg == LAST_IDX) ? '0 : scan_idx_reg + 1'b1;
            end else if (state_next == SCAN) begin
                // Fresh scan: restart the minimum search.
                min_deadline_reg <= '1;
                found_reg        <= 1'b0;
                scan_idx_reg     <= '0;
            end
        end
    end

    // Slot table. Arm beats cancel on the same slot; fire only happens
    // outside IDLE, so it never collides with a request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_reg <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                deadline_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (arm_accept && (arm_slot_i == SW'(i))) begin
                    armed_reg[i]    <= 1'b1;
                    deadline_reg[i] <= arm_deadline_i;
                end else if (cancel_accept && (cancel_slot_i == SW'(i))) begin
                    armed_reg[i] <= 1'b0;
                end else if (in_fire && expired[i]) begin
                    armed_reg[i] <= 1'b0;
                end
            end
        end
    end

    // A set from FIRE wins over an ack in the same cycle.
    assign pending_next = (pending_reg & ~event_ack_i) | (in_fire ? expired : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pending_reg <= '0;
        else
            pending_reg <= pending_next;
    end

    assign event_pending_o = pending_reg;
    assign irq_o           = |pending_reg;

endmodule

// File: doc/timer_event_scheduler.md
TIMER_EVENT_SCHEDULER -- requirements
Module: timer_event_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4, meaning the number of independent software timer event slots (2..8).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have port arm_valid_i / arm_ready_o, input / output, 1 / 1, the arm request handshake.
REQ-005 The block SHALL have port arm_slot_i, input, $clog2(NUM_SLOTS), the slot to arm.
REQ-006 The block SHALL have port arm_deadline_i, input, 64, the absolute timer value at which the slot fires.
REQ-007 The block SHALL have port cancel_valid_i / cancel_slot_i, input, 1 / $clog2(NUM_SLOTS), a slot disarm request.
REQ-008 The block SHALL have port timer_value_i, input, 64, the current timer count {high, low}.
REQ-009 The block SHALL have port timer_interrupt_i, input, 1, the level compare-match from the timer.
REQ-010 The block SHALL have ports timer_write_o / timer_write_data_o / timer_write_address_o, output, 1 / 32 / 2, the timer register write port.
REQ-011 The block SHALL have ports event_pending_o / event_ack_i, output / input, NUM_SLOTS, per-slot pending flags and their write-1-to-clear acks.
REQ-012 The block SHALL have port irq_o, output, 1, the OR of event_pending_o.

Function
REQ-013 The FSM SHALL have the states IDLE, SCAN, WR_HI_MAX, WR_LO, WR_HI and FIRE.
REQ-014 arm_ready_o SHALL be 1 only in IDLE; arm and cancel requests SHALL be accepted only in IDLE and ignored in every other state.
REQ-015 An accepted arm SHALL set the slot armed with its deadline, overwriting any prior deadline; an accepted cancel SHALL clear armed for its slot.
REQ-016 Arm and cancel to the same slot in one cycle SHALL resolve to arm; to different slots, both SHALL apply.
REQ-017 Any accepted arm or cancel SHALL transition IDLE->SCAN.
REQ-018 In SCAN, one slot per cycle (index 0..NUM_SLOTS-1) SHALL be compared unsigned 64-bit into min_deadline (start all ones), with a found flag; SCAN SHALL last exactly NUM_SLOTS cycles.
REQ-019 At the end of SCAN, if found and min_deadline <= timer_value_i, the FSM SHALL go to FIRE; otherwise it SHALL go to WR_HI_MAX.
REQ-020 When no slot is armed, the compare target SHALL be all ones.
REQ-021 WR_HI_MAX SHALL write 0xFFFFFFFF to address 1 (COMPARE_HIGH); WR_LO SHALL write target[31:0] to address 0; WR_HI SHALL write target[63:32] to address 1 and then go to IDLE.
REQ-022 The write outputs SHALL be Moore outputs, high for exactly one cycle per WR_* state, with write 0, data 0 and address 0 otherwise.
REQ-023 Arm latency SHALL be accept at T, three writes at T+NUM_SLOTS+1..+3, and IDLE at T+NUM_SLOTS+4.
REQ-024 In IDLE, timer_interrupt_i=1 with at least one slot armed SHALL go to FIRE; with no slot armed the interrupt SHALL be ignored; it SHALL be ignored in all other states.
REQ-025 FIRE SHALL last one cycle: every armed slot with deadline <= timer_value_i SHALL be disarmed with its pending bit set, then the FSM SHALL go to SCAN.
REQ-026 An arm that is accepted in the same cycle as timer_interrupt_i SHALL take priority, with the FSM going to SCAN.
REQ-027 The interrupt SHALL be re-detected through the expired check at the end of SCAN.
REQ-028 A pending bit SHALL clear on its event_ack_i bit; a set in FIRE on the same cycle SHALL win over the ack.

Reset
REQ-029 rst_i SHALL asynchronously force: state IDLE, all slots disarmed, deadlines 0, min_deadline all ones, SCAN index 0, event_pending_o 0, irq_o 0, timer write outputs 0, arm_ready_o 1.
REQ-030 A reset mid-sequence SHALL abandon the sequence; no further writes SHALL occur, because the timer's own reset restores compare to all ones.

Structure
REQ-031 The timer register address constants COMPARE_LOW=0, COMPARE_HIGH=1, TIMER_VALUE_LOW=2 and TIMER_VALUE_HIGH=3 SHALL be placed in apogeo_pkg, together with the enum timer_sched_state_t.
REQ-032 The block SHALL be a single module with no sub-modules; the slot table SHALL be flops, not memory.

Verification
REQ-033 Bench: reset, arm slot 2 deadline 0x0000_0001_0000_0100 at timer 0x10 -> writes (1,0xFFFFFFFF), (0,0x00000100), (1,0x00000001) at T+5..T+7; IDLE at T+8.
REQ-034 Bench: arm slots 0=500 and 1=300, raise interrupt at timer 300 -> FIRE sets pending[1] only; re-SCAN programs compare 500.
REQ-035 Bench: arm slot 3 deadline 50 with timer 80 -> FIRE after SCAN, pending[3]=1, no compare writes, then writes all ones.
REQ-036 Bench: arm and cancel slot 1 in the same cycle -> slot 1 armed; cancel slot 1 alone -> compare reprogrammed to all ones.
REQ-037 Bench: ack pending[0] in the same cycle FIRE sets it -> pending[0] stays 1; ack on the next cycle -> 0, irq_o 0.
REQ-038 Bench: assert rst_i during WR_LO -> outputs 0 immediately, state IDLE, arm_ready_o 1, no further writes.
